// File: rtl/ram_read_controller.sv
// Reads num_rows rows from the output BRAM port B and streams them downstream over valid/ready.
// Optional macro ROW_PARITY_EN: registers a per-row 32-bit XOR signature on dout_parity.
module ram_read_controller #(
  parameter int DATA_W = 1024,
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 32,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              read_C,
  input  logic [ADDR_W:0]   num_rows,
  input  logic              finish,
  output logic [ADDR_W-1:0] r_addr,
  output logic              r_en,
  input  logic [DATA_W-1:0] r_data,
  output logic [DATA_W-1:0] dout,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [31:0]       dout_parity,
  output logic              busy,
  output logic              read_C_done
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_PRESENT,
    S_DONE
  } state_t;

  localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] ONE_C    = (ADDR_W+1)'(1);
  localparam logic [1:0]      LAT_LAST = 2'(RD_LAT-1);

  state_t              state_q;
  logic                read_C_last_q;
  logic [ADDR_W:0]     rows_q;
  logic [ADDR_W:0]     row_cnt_q;
  logic [1:0]          lat_cnt_q;
  logic [ADDR_W-1:0]   r_addr_q;
  logic                r_en_q;
  logic [DATA_W-1:0]   dout_q;
  logic                dout_valid_q;
  logic                done_q;

  logic                start_d;
  logic [ADDR_W:0]     rows_d;
  logic                last_row_d;
  logic                capture_d;

  assign start_d    = (state_q == S_IDLE) && read_C && !read_C_last_q && !finish;
  assign rows_d     = ((num_rows == '0) || (num_rows > DEPTH_C)) ? DEPTH_C : num_rows;
  assign last_row_d = (row_cnt_q == (rows_q - ONE_C));
  assign capture_d  = (state_q == S_WAIT) && (lat_cnt_q == LAT_LAST) && !finish;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      read_C_last_q <= 1'b0;
      rows_q        <= '0;
      row_cnt_q     <= '0;
      lat_cnt_q     <= '0;
      r_addr_q      <= '0;
      r_en_q        <= 1'b0;
      dout_q        <= '0;
      dout_valid_q  <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      read_C_last_q <= read_C;
      // Abort outranks every transition, including a same-cycle handshake.
      if (finish && (state_q != S_IDLE)) begin
        state_q      <= S_IDLE;
        r_en_q       <= 1'b0;
        dout_valid_q <= 1'b0;
        done_q       <= 1'b0;
      end else begin
        case (state_q)
          S_IDLE: begin
            done_q <= 1'b0;
            if (start_d) begin
              state_q   <= S_ISSUE;
              r_addr_q  <= '0;
              row_cnt_q <= '0;
              rows_q    <= rows_d;
              r_en_q    <= 1'b1;
            end
          end
          S_ISSUE: begin
            r_en_q    <= 1'b0;
            lat_cnt_q <= '0;
            state_q   <= S_WAIT;
          end
          S_WAIT: begin
            if (lat_cnt_q == LAT_LAST) begin
              dout_q       <= r_data;
              dout_valid_q <= 1'b1;
              state_q      <= S_PRESENT;
            end else begin
              lat_cnt_q <= lat_cnt_q + 2'd1;
            end
          end
          S_PRESENT: begin
            if (dout_ready) begin
              dout_valid_q <= 1'b0;
              if (last_row_d) begin
                state_q <= S_DONE;
                done_q  <= 1'b1;
              end else begin
                row_cnt_q <= row_cnt_q + ONE_C;
                r_addr_q  <= r_addr_q + ADDR_W'(1);
                r_en_q    <= 1'b1;
                state_q   <= S_ISSUE;
              end
            end
          end
          S_DONE: begin
            done_q  <= 1'b0;
            state_q <= S_IDLE;
          end
          default: state_q <= S_IDLE;
        endcase
      end
    end
  end

`ifdef ROW_PARITY_EN
  function automatic logic [31:0] row_xor(input logic [DATA_W-1:0] d);
    logic [31:0] acc;
    acc = '0;
    for (int i = 0; i < DATA_W/32; i++) begin
      acc = acc ^ d[i*32 +: 32];
    end
    return acc;
  endfunction

  logic [31:0] parity_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      parity_q <= '0;
    end else if (capture_d) begin
      parity_q <= row_xor(r_data);
    end
  end

  assign dout_parity = parity_q;
`else
  logic unused_capture;
  assign unused_capture = capture_d;
  assign dout_parity    = 32'h0;
`endif

  assign r_addr      = r_addr_q;
  assign r_en        = r_en_q;
  assign dout        = dout_q;
  assign dout_valid  = dout_valid_q;
  assign busy        = (state_q != S_IDLE);
  assign read_C_done = done_q;

endmodule

// File: tb/tb_ram_read_controller.sv
// Randomized bench for ram_read_controller: BRAM model, expected-row queue and per-job bookkeeping.
module tb_ram_read_controller;

  localparam int DATA_W = 1024;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int RD_LAT = 1;
  localparam int NW     = DATA_W/32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              read_C = 1'b0;
  logic [ADDR_W:0]   num_rows = '0;
  logic              finish = 1'b0;
  logic [ADDR_W-1:0] r_addr;
  logic              r_en;
  logic [DATA_W-1:0] r_data;
  logic [DATA_W-1:0] dout;
  logic              dout_valid;
  logic              dout_ready = 1'b0;
  logic [31:0]       dout_parity;
  logic              busy;
  logic              read_C_done;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ram_read_controller #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst_n(rst_n), .read_C(read_C), .num_rows(num_rows), .finish(finish),
    .r_addr(r_addr), .r_en(r_en), .r_data(r_data), .dout(dout), .dout_valid(dout_valid),
    .dout_ready(dout_ready), .dout_parity(dout_parity), .busy(busy), .read_C_done(read_C_done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [63:0] fold64(input logic [DATA_W-1:0] d);
    logic [63:0] acc;
    acc = '0;
    for (int i = 0; i < DATA_W/64; i++) acc = {acc[62:0], acc[63]} ^ d[i*64 +: 64];
    return acc;
  endfunction

  function automatic logic [31:0] exp_par(input logic [DATA_W-1:0] d);
    logic [31:0] acc;
    acc = '0;
`ifdef ROW_PARITY_EN
    for (int i = 0; i < NW; i++) acc = acc ^ d[i*32 +: 32];
`endif
    return acc;
  endfunction

  // BRAM port-B model: read latched on r_en, then delayed RD_LAT-1 more cycles, output held.
  logic [DATA_W-1:0] mem  [DEPTH];
  logic [DATA_W-1:0] pipe [RD_LAT];
  always @(posedge clk) begin
    if (r_en) pipe[0] <= mem[r_addr];
    for (int k = 1; k < RD_LAT; k++) pipe[k] <= pipe[k-1];
  end
  assign r_data = pipe[RD_LAT-1];

  // Single driver for dout_ready: random or manual.
  int ready_pct = 100;
  bit ready_auto = 1'b1;
  bit ready_man = 1'b1;
  initial forever begin
    @(posedge clk);
    #2;
    dout_ready = ready_auto ? ($urandom_range(99) < ready_pct) : ready_man;
  end

  // Stream monitor and scoreboard.
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] dout_prev;
  logic [DATA_W-1:0] row;
  int exp_addr = 0, ren_cnt = 0, done_cnt = 0, pops = 0;
  bit mon_en = 1'b0;
  bit stall_prev = 1'b0;

  always @(negedge clk) begin
    if (mon_en) begin
      if (r_en) begin
        chk("r_addr", 64'(r_addr), 64'(exp_addr));
        exp_addr++;
        ren_cnt++;
      end
      if (stall_prev) begin
        chk("stall_valid", 64'(dout_valid), 64'd1);
        chk("stall_data", fold64(dout), fold64(dout_prev));
      end
      if (dout_valid && dout_ready) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_row", 64'(exp_q.size()), 64'd1);
        end else begin
          row = exp_q.pop_front();
          chk("row_lo", dout[63:0], row[63:0]);
          chk("row_fold", fold64(dout), fold64(row));
          chk("parity", 64'(dout_parity), 64'(exp_par(row)));
          pops++;
        end
      end
      if (read_C_done) begin
        done_cnt++;
        chk("done_after_last", 64'(exp_q.size()), 64'd0);
      end
      stall_prev = dout_valid && !dout_ready;
      dout_prev  = dout;
    end
  end

  task automatic flush();
    exp_q.delete();
    stall_prev = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < DEPTH; i++)
      for (int w = 0; w < NW; w++) mem[i][w*32 +: 32] = $urandom();
  endtask

  task automatic start_job(input int n, output int n_eff);
    n_eff = (n == 0 || n > DEPTH) ? DEPTH : n;
    @(posedge clk); #1;
    read_C = 1'b1;
    num_rows = (ADDR_W+1)'(n);
    @(posedge clk); #1;
    for (int i = 0; i < n_eff; i++) exp_q.push_back(mem[i]);
    exp_addr = 0; ren_cnt = 0; done_cnt = 0; pops = 0;
    chk("busy_after_start", 64'(busy), 64'd1);
  endtask

  task automatic wait_idle(input int bound);
    for (int i = 0; i < bound && busy; i++) begin
      @(posedge clk); #1;
    end
    chk("idle_reached", 64'(busy), 64'd0);
  endtask

  task automatic end_checks(input int ne);
    repeat (2) @(posedge clk);
    #1;
    chk("rows_left", 64'(exp_q.size()), 64'd0);
    chk("ren_count", 64'(ren_cnt), 64'(ne));
    chk("rows_seen", 64'(pops), 64'(ne));
    chk("done_count", 64'(done_cnt), 64'd1);
  endtask

  task automatic run_job(input int n, input int pct);
    int ne, e;
    ready_auto = 1'b1;
    ready_pct = pct;
    start_job(n, ne);
    read_C = 1'b0;
    e = 0;
    while (!dout_valid && e < 40) begin
      @(posedge clk); #1;
      e++;
    end
    chk("first_valid_lat", 64'(e), 64'(RD_LAT+1));
    wait_idle(5000);
    end_checks(ne);
  endtask

  initial begin
    int ne, snap, busy_cyc;
    for (int i = 0; i < DEPTH; i++) mem[i] = {NW{32'(i+1)}};
    for (int k = 0; k < RD_LAT; k++) pipe[k] = '0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_valid", 64'(dout_valid), 64'd0);
    chk("rst_ren", 64'(r_en), 64'd0);
    chk("rst_addr", 64'(r_addr), 64'd0);
    chk("rst_dout", fold64(dout), 64'd0);
    chk("rst_done", 64'(read_C_done), 64'd0);
    chk("rst_parity", 64'(dout_parity), 64'd0);
    rst_n = 1'b1;
    mon_en = 1'b1;

    // Pattern rows, then zero and oversize row counts.
    run_job(4, 100);
    chk("last_addr_4", 64'(r_addr), 64'd3);
    run_job(0, 100);
    chk("last_addr_0", 64'(r_addr), 64'(DEPTH-1));
    run_job(40, 100);
    chk("last_addr_40", 64'(r_addr), 64'(DEPTH-1));

    // Backpressure on the row at address 2.
    ready_auto = 1'b0;
    ready_man = 1'b1;
    start_job(4, ne);
    read_C = 1'b0;
    for (int i = 0; i < 100 && !(dout_valid && r_addr == 2); i++) begin
      @(posedge clk); #1;
    end
    ready_man = 1'b0;
    chk("bp_row2_valid", 64'(dout_valid), 64'd1);
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_valid", 64'(dout_valid), 64'd1);
      chk("bp_ren", 64'(r_en), 64'd0);
      chk("bp_addr", 64'(r_addr), 64'd2);
    end
    ready_man = 1'b1;
    wait_idle(500);
    end_checks(ne);

    // Random contents, sizes and backpressure.
    for (int j = 0; j < 6; j++) begin
      fill_random();
      run_job($urandom_range(0, 40), $urandom_range(20, 100));
    end

    // Abort on row 3 of 8 with ready high.
    fill_random();
    ready_auto = 1'b1;
    ready_pct = 100;
    start_job(8, ne);
    read_C = 1'b0;
    for (int i = 0; i < 200 && !(dout_valid && pops == 2); i++) begin
      @(posedge clk); #1;
    end
    chk("abort_at_row3", 64'(pops), 64'd2);
    finish = 1'b1;
    @(posedge clk); #1;
    finish = 1'b0;
    chk("abort_busy", 64'(busy), 64'd0);
    chk("abort_valid", 64'(dout_valid), 64'd0);
    snap = ren_cnt;
    repeat (6) @(posedge clk);
    #1;
    chk("abort_no_ren", 64'(ren_cnt), 64'(snap));
    chk("abort_ren_total", 64'(ren_cnt), 64'd3);
    chk("abort_no_done", 64'(done_cnt), 64'd0);
    flush();
    run_job(3, 100);

    // read_C toggled while busy, then held high across DONE.
    fill_random();
    ready_pct = 60;
    start_job(6, ne);
    read_C = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      read_C = ~read_C;
    end
    read_C = 1'b1;
    wait_idle(1000);
    busy_cyc = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (busy) busy_cyc++;
    end
    chk("no_second_job", 64'(busy_cyc), 64'd0);
    chk("toggle_done_count", 64'(done_cnt), 64'd1);
    chk("toggle_rows_seen", 64'(pops), 64'(ne));
    read_C = 1'b0;

    // Parity signature rows.
    mem[0] = {NW{32'hA5A5A5A5}};
    mem[1] = '0;
    mem[1][31:0] = 32'h1;
    run_job(1, 100);
    chk("parity_a5", 64'(dout_parity), 64'd0);
    ready_auto = 1'b0;
    ready_man = 1'b0;
    flush();
    start_job(2, ne);
    read_C = 1'b0;
    for (int i = 0; i < 100 && !(dout_valid && r_addr == 1); i++) begin
      @(posedge clk); #1;
    end
`ifdef ROW_PARITY_EN
    chk("parity_word0", 64'(dout_parity), 64'h1);
`else
    chk("parity_off", 64'(dout_parity), 64'h0);
`endif
    ready_man = 1'b1;
    wait_idle(200);
    end_checks(ne);

    // Reset in the middle of a job.
    ready_auto = 1'b1;
    ready_pct = 100;
    start_job(8, ne);
    read_C = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_valid", 64'(dout_valid), 64'd0);
    chk("midrst_ren", 64'(r_en), 64'd0);
    chk("midrst_dout", fold64(dout), 64'd0);
    chk("midrst_done", 64'(read_C_done), 64'd0);
    mon_en = 1'b0;
    flush();
    @(posedge clk); #1;
    rst_n = 1'b1;
    mon_en = 1'b1;
    run_job(2, 100);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/ram_read_controller.md
Name: ram_read_controller

Overview:
- Read-side counterpart of the C-matrix output BRAM writer.
- On a start request it reads a programmable number of result rows from the output BRAM's read port B, starting at address 0.
- Each row is presented downstream on a registered valid/ready stream, one 1024-bit row per handshake.
- Sits between the Bram_Output read port (addrb/doutb) and the host/readback path; pulses a done flag after the last row is accepted.

Parameters:
- DATA_W, 1024, row width in bits; must be a multiple of 32.
- ADDR_W, 5, BRAM address width.
- DEPTH, 32, number of BRAM rows; must be ≤ 2^ADDR_W.
- RD_LAT, 1, BRAM read latency in cycles; legal range 1..3.

Ports:
- clk  in  1  single clock for the whole block.
- rst_n  in  1  asynchronous, active-low reset.
- read_C  in  1  start request; level signal, only its rising edge is acted on.
- num_rows  in  ADDR_W+1  rows to read; sampled on the accepted start edge.
- finish  in  1  synchronous abort; returns the block to IDLE.
- r_addr  out  ADDR_W  BRAM port-B address (addrb).
- r_en  out  1  one-cycle read strobe per row.
- r_data  in  DATA_W  BRAM port-B data (doutb).
- dout  out  DATA_W  registered row data.
- dout_valid  out  1  row valid.
- dout_ready  in  1  downstream accept.
- dout_parity  out  32  row checksum; see Optional Feature.
- busy  out  1  high in every state except IDLE.
- read_C_done  out  1  one-cycle pulse after the final row handshake.

Behaviour:
- Reset (asynchronous, active-low): all outputs 0, state IDLE, row counter 0, read_C_last 0, num_rows latch 0.
- Edge detect:
  - read_C_last is registered every cycle.
  - Start is accepted when read_C && !read_C_last is true in IDLE.
  - Rising edges in any other state are ignored; they are not queued.
- num_rows latch: value 0 is treated as DEPTH; values > DEPTH are clamped to DEPTH.
- FSM states: IDLE, ISSUE, WAIT, PRESENT, DONE.
  - IDLE -> ISSUE on accepted start. Same edge: r_addr=0, row_cnt=0, num_rows latched.
  - ISSUE (1 cycle): r_en=1, r_addr held; lat_cnt cleared. -> WAIT.
  - WAIT: r_en=0, lat_cnt increments each cycle.
    - When lat_cnt==RD_LAT-1: dout<=r_data, dout_valid<=1, -> PRESENT.
  - PRESENT: dout and dout_valid stay stable until dout_ready=1 (standard valid/ready rule; dout_valid never drops without a handshake).
    - On handshake with row_cnt==rows-1: dout_valid<=0, -> DONE.
    - On any other handshake: dout_valid<=0, row_cnt++, r_addr++, -> ISSUE.
  - DONE (1 cycle): read_C_done=1, -> IDLE.
- Latency: the first dout_valid rises RD_LAT+1 clock edges after the edge that leaves IDLE.
- Throughput: with dout_ready held high, one row per RD_LAT+2 cycles.
- r_addr is held constant from ISSUE until capture, so the BRAM output is stable whatever RD_LAT is.
- r_addr never exceeds DEPTH-1; no wrap occurs within one job.
- Each new job restarts at address 0.
- finish=1 in any non-IDLE state (highest priority, including the same cycle as a handshake):
  - Next state IDLE, dout_valid=0, r_en=0, read_C_done is not pulsed.
  - dout retains its last value.
- finish in IDLE has no effect. finish and an accepted start in the same cycle: finish wins and the start is dropped.
- A new start is accepted no earlier than the cycle after DONE, and only if read_C has returned low and risen again.
- Reset asserted mid-job: immediate IDLE; the stream is dropped with no done pulse.

Optional Feature:
- Macro: ROW_PARITY_EN.
- Defined:
  - dout_parity is registered alongside dout at capture.
  - Value is the XOR of the DATA_W/32 32-bit words of r_data, word 0 = bits [31:0].
  - Gives the fault-tolerance checker a per-row signature.
- Undefined: dout_parity is tied to 32'h0 and no XOR logic is built.

Test Plan:
- BRAM model preloaded with row i = {32{i+1}}; read_C rise, num_rows=4, dout_ready=1 -> rows 1..4 on dout, r_addr 0,1,2,3, first dout_valid 2 edges after leaving IDLE (RD_LAT=1), read_C_done single pulse after 4th handshake.
- num_rows=0 -> exactly 32 rows, last r_addr=31, then done; num_rows=40 -> also 32 rows.
- Backpressure: dout_ready low 5 cycles while row 2 is valid -> dout/dout_valid stable for those 5 cycles, no r_en, r_addr stays 2.
- finish asserted in PRESENT on row 3 of 8 with dout_ready=1 -> no further r_en, busy=0 next cycle, no read_C_done; a subsequent fresh read_C rise restarts at address 0.
- read_C toggled while busy, and held high across DONE -> no second job; RD_LAT=3 build -> first dout_valid 4 edges after leaving IDLE.
- ROW_PARITY_EN defined, row = {32{32'hA5A5A5A5}} -> dout_parity=0; row word0=32'h1, others 0 -> dout_parity=32'h1. Macro undefined -> dout_parity=0 always.
